rpn_cmd_scheduler: RTL and testbench
====================================

# rpn_cmd_scheduler

Sequences keypad commands into the calculator CPU's ATC (attention/test) input register, so the program loop sees at most one command bit at a time. It:

- synchronises and edge-detects four command buttons (MULT, ADD, POP, PUSH);
- resolves simultaneous presses by fixed priority;
- buffers commands in a small FIFO;
- presents each command as a one-hot ATC bit until the CPU acknowledges it.

It sits between the debounced keypad and the CPU's ATC port. ATC bit 4 carries the arithmetic-overflow flag.

## Interface
Parameters:
- DEPTH, 4, command FIFO entries; power of two, at least 2
- SYNC_STAGES, 2, synchroniser flops per button input
- HOLDOFF, 2, idle cycles after each acknowledge before the next command is presented

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- btn_mult, btn_add, btn_pop, btn_push  in  1 each  debounced, asynchronous, active-high buttons
- arith_ovf  in  1  CPU arithmetic-overflow status, synchronous to clk
- atc_ack  in  1  one-cycle pulse when the CPU has consumed the presented command
- atc_bits  out  8  CPU ATC register image
  - [0] MULT, [1] ADD, [2] POP, [3] PUSH
  - [4] overflow
  - [7:5] always 0
- busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy
- drop_cnt  out  8  count of dropped presses; saturates at 255

## Operation
- Each button passes through SYNC_STAGES flops, then a rising-edge detector; edge_det is a one-cycle pulse per press.
- Pending register, 4 bits:
  - edge_det sets the corresponding pending bit.
  - An edge on a bit that is already pending increments drop_cnt; the bit stays set.
- Enqueue:
  - Each cycle, the highest-priority pending bit (MULT > ADD > POP > PUSH) is written to the FIFO as a 2-bit code: MULT=0, ADD=1, POP=2, PUSH=3.
  - Its pending bit clears in the same cycle.
  - At most one write per cycle.
  - A write is permitted if fifo_level < DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the bit stays pending; nothing is dropped.
- Issue FSM:
  - IDLE → PRESENT when the FIFO is non-empty: pop the head and register atc_bits[code] = 1.
  - PRESENT: hold the one-hot bit until atc_ack, then clear atc_bits[3:0] and go to HOLDOFF with counter = HOLDOFF−1.
  - HOLDOFF: decrement each cycle; at 0 go to IDLE. If HOLDOFF = 0, go straight from PRESENT to IDLE.
  - atc_ack outside PRESENT is ignored.
- atc_bits[4] is arith_ovf registered once. It is independent of the FSM.

## Timing
- Reset value of every output is 0: atc_bits = 0, busy = 0, fifo_level = 0, drop_cnt = 0. Pending, FIFO and FSM (IDLE) are cleared asynchronously.
- Reset asserted mid-command clears the presented bit immediately; queued commands are lost.
- Latency, with FIFO empty and FSM in IDLE:
  - edge_det high in cycle t → pending set at end of t
  - FIFO written at end of t+1
  - atc_bits one-hot visible from cycle t+3
- atc_ack sampled in cycle a → atc_bits[3:0] = 0 from a+1.
- The next command appears no earlier than a+2+HOLDOFF.
- Simultaneous edges on all four buttons in cycle t → FIFO writes in t+1 … t+4 in priority order. Presentation order: MULT, ADD, POP, PUSH.
- FIFO pointers wrap modulo DEPTH. fifo_level is exact, including for a simultaneous write and pop.
- drop_cnt holds at 255.

## Structure
- Package rpn_cmd_pkg holds:
  - cmd enum, 2 bits: CMD_MULT, CMD_ADD, CMD_POP, CMD_PUSH
  - ATC bit-position constants: MULT=0, ADD=1, POP=2, PUSH=3, OVF=4
  - FSM state enum: IDLE, PRESENT, HOLDOFF
- One sub-module, rpn_cmd_fifo:
  - synchronous FIFO, DEPTH × 2 bits
  - push/pop/full/empty/level
  - async active-low reset
- Synchroniser, edge detector, pending/priority logic and issue FSM live in rpn_cmd_scheduler.

## Test plan
- Reset: hold reset_n low with all buttons low → all outputs 0. Release and press PUSH → atc_bits = 8'h08 three cycles after edge_det.
- Ack handshake with HOLDOFF=2: ADD presented; atc_ack in cycle a → atc_bits[3:0] = 0 at a+1. A queued POP appears as 8'h04 at a+4.
- Priority:
  - all four buttons rise in the same cycle → presented sequence 01, 02, 04, 08
  - each presentation is acked
  - drop_cnt = 0
- Overflow/drop with DEPTH=4 and no acks: 5 distinct press pairs → fifo_level = 4 after the first is presented, extra repeats increment drop_cnt. Force drop_cnt to saturate → stays 255.
- arith_ovf = 1 while MULT is presented → atc_bits = 8'h11 one cycle later. Ack → 8'h10.
- Reset mid-operation: assert reset_n low during PRESENT with 3 entries queued → atc_bits = 0 and fifo_level = 0 asynchronously. After release, busy = 0.

Source files
------------

// File: rtl/rpn_cmd_pkg.sv
// Shared types and constants for the keypad command scheduler.
package rpn_cmd_pkg;

  // 2-bit command code stored in the FIFO; value equals its ATC bit position.
  typedef enum logic [1:0] {
    CMD_MULT = 2'd0,
    CMD_ADD  = 2'd1,
    CMD_POP  = 2'd2,
    CMD_PUSH = 2'd3
  } cmd_e;

  // ATC register bit positions.
  localparam int ATC_MULT = 0;
  localparam int ATC_ADD  = 1;
  localparam int ATC_POP  = 2;
  localparam int ATC_PUSH = 3;
  localparam int ATC_OVF  = 4;

  // Issue FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  // One-hot ATC image of a command code.
  function automatic logic [3:0] cmd_onehot(input logic [1:0] code);
    return 4'b0001 << code;
  endfunction

  // Highest-priority pending command (MULT > ADD > POP > PUSH).
  function automatic cmd_e prio_pick(input logic [3:0] pend);
    if (pend[ATC_MULT])     return CMD_MULT;
    else if (pend[ATC_ADD]) return CMD_ADD;
    else if (pend[ATC_POP]) return CMD_POP;
    else                    return CMD_PUSH;
  endfunction

endpackage

// File: rtl/rpn_cmd_fifo.sv
// Small synchronous FIFO for 2-bit command codes with exact occupancy count.
// push is honoured when not full or when a pop happens in the same cycle;
// pop is honoured only when not empty. rd_data shows the head combinationally.
module rpn_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [W-1:0]             wr_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign rd_ok   = pop && !empty;
  assign wr_ok   = push && (!full || rd_ok);
  assign rd_data = mem[rd_ptr];

  // Storage, pointers (wrap modulo DEPTH) and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/rpn_cmd_scheduler.sv
// Keypad command scheduler: synchronises four buttons, edge-detects them,
// latches presses in a pending register, enqueues them by fixed priority and
// presents one command at a time on the CPU ATC register until acknowledged.
// Handshake: atc_ack is a one-cycle pulse that is only honoured while a
// command is presented; the next command never appears before HOLDOFF idle
// cycles have elapsed after the acknowledge.
module rpn_cmd_scheduler
  import rpn_cmd_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF     = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   btn_mult,
  input  logic                   btn_add,
  input  logic                   btn_pop,
  input  logic                   btn_push,
  input  logic                   arith_ovf,
  input  logic                   atc_ack,
  output logic [7:0]             atc_bits,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [7:0]             drop_cnt
);

  localparam int CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  logic [3:0]    btn_vec;
  logic [3:0]    sync_q [SYNC_STAGES];
  logic [3:0]    prev_q;
  logic [3:0]    edge_det;
  logic [3:0]    pending;
  logic [3:0]    drops;
  logic [2:0]    drop_num;
  logic [8:0]    drop_sum;
  logic          grant_valid;
  cmd_e          grant_code;
  logic [3:0]    grant_mask;
  logic          fifo_wr;
  logic          fifo_rd;
  logic [1:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  state_e        fsm_state;
  logic [CW-1:0] hold_cnt;
  logic [3:0]    cmd_bits;
  logic          ovf_q;

  // Bit order matches ATC positions so bit i always means the same command.
  assign btn_vec = {btn_push, btn_pop, btn_add, btn_mult};

  // Synchroniser chain plus previous-value flop for rising-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= btn_vec;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign drops    = edge_det & pending;

  // Priority select of one pending command; a full FIFO only accepts it
  // when the issue FSM pops in the same cycle, otherwise it stays pending.
  assign grant_valid = |pending;
  assign grant_code  = prio_pick(pending);
  assign fifo_rd     = (fsm_state == ST_IDLE) && !fifo_empty;
  assign fifo_wr     = grant_valid && (!fifo_full || fifo_rd);
  assign grant_mask  = fifo_wr ? cmd_onehot(grant_code) : 4'b0000;

  // Number of presses that hit an already-pending command this cycle.
  always_comb begin
    drop_num = '0;
    for (int i = 0; i < 4; i++) drop_num = drop_num + {2'b00, drops[i]};
  end

  assign drop_sum = {1'b0, drop_cnt} + {6'b000000, drop_num};

  // Pending register and saturating drop counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= '0;
      drop_cnt <= '0;
    end else begin
      pending  <= (pending & ~grant_mask) | edge_det;
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  rpn_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (2)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_wr),
    .wr_data (grant_code),
    .pop     (fifo_rd),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Issue FSM: present the FIFO head, wait for ack, then hold off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_state <= ST_IDLE;
      hold_cnt  <= '0;
      cmd_bits  <= '0;
    end else begin
      case (fsm_state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            cmd_bits  <= cmd_onehot(fifo_head);
            fsm_state <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (atc_ack) begin
            cmd_bits <= '0;
            if (HOLDOFF == 0) begin
              fsm_state <= ST_IDLE;
            end else begin
              hold_cnt  <= CW'(HOLDOFF - 1);
              fsm_state <= ST_HOLDOFF;
            end
          end
        end
        ST_HOLDOFF: begin
          if (hold_cnt == '0) fsm_state <= ST_IDLE;
          else                hold_cnt  <= hold_cnt - CW'(1);
        end
        default: fsm_state <= ST_IDLE;
      endcase
    end
  end

  // Overflow flag is a plain one-cycle register, independent of the FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ovf_q <= 1'b0;
    else          ovf_q <= arith_ovf;
  end

  assign atc_bits = {3'b000, ovf_q, cmd_bits};
  assign busy     = (fsm_state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_rpn_cmd_scheduler.sv
// Self-checking bench for rpn_cmd_scheduler (DEPTH=4, SYNC_STAGES=2, HOLDOFF=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge. Pressing a button at the start of cycle c0 gives edge_det in
// c0+2, so the one-hot command is expected from c0+5.
module tb_rpn_cmd_scheduler;

  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int HOLDOFF     = 2;

  localparam logic [3:0] B_MULT = 4'b0001;
  localparam logic [3:0] B_ADD  = 4'b0010;
  localparam logic [3:0] B_POP  = 4'b0100;
  localparam logic [3:0] B_PUSH = 4'b1000;

  // Clock / reset block
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic btn_mult = 1'b0, btn_add = 1'b0, btn_pop = 1'b0, btn_push = 1'b0;
  logic arith_ovf = 1'b0;
  logic atc_ack = 1'b0;
  logic [7:0] atc_bits;
  logic       busy;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [7:0] drop_cnt;

  rpn_cmd_scheduler #(
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC_STAGES),
    .HOLDOFF     (HOLDOFF)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_mult   (btn_mult),
    .btn_add    (btn_add),
    .btn_pop    (btn_pop),
    .btn_push   (btn_push),
    .arith_ovf  (arith_ovf),
    .atc_ack    (atc_ack),
    .atc_bits   (atc_bits),
    .busy       (busy),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [3:0] btn;
    logic       ovf;
    logic [7:0] exp_atc;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btns(input logic [3:0] m);
    {btn_push, btn_pop, btn_add, btn_mult} = m;
  endtask

  task automatic press(input logic [3:0] m);
    set_btns(m);
    repeat (3) tick();
    set_btns(4'b0000);
    repeat (3) tick();
  endtask

  // Scoreboard: wait (bounded) for the next presentation, compare with the
  // queue head, acknowledge and confirm the command bits clear at a+1.
  task automatic expect_next(input string name);
    logic [7:0] exp;
    int n;
    exp = exp_q.pop_front();
    n = 0;
    @(negedge clk);
    while (atc_bits[3:0] == 4'h0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, atc_bits, exp);
    tick();
    atc_ack = 1'b1;
    tick();
    atc_ack = 1'b0;
    @(negedge clk);
    check({name, "_ackclr"}, atc_bits[3:0], 4'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    vecs[0] = '{btn: B_PUSH, ovf: 1'b0, exp_atc: 8'h08};
    vecs[1] = '{btn: B_MULT, ovf: 1'b0, exp_atc: 8'h01};
    vecs[2] = '{btn: B_ADD,  ovf: 1'b0, exp_atc: 8'h02};
    vecs[3] = '{btn: B_POP,  ovf: 1'b0, exp_atc: 8'h04};
    vecs[4] = '{btn: B_MULT, ovf: 1'b1, exp_atc: 8'h11};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_atc", atc_bits, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_level", fifo_level, 0);
    check("rst_drop", drop_cnt, 8'h00);
    reset_n = 1'b1;
    repeat (3) tick();

    // Single-command vectors: exact latency, ack clear, holdoff, idle
    for (int i = 0; i < 5; i++) begin
      arith_ovf = vecs[i].ovf;
      tick();
      set_btns(vecs[i].btn);
      repeat (4) tick();
      @(negedge clk);
      check($sformatf("vec%0d_early", i), atc_bits, {3'b000, vecs[i].ovf, 4'h0});
      set_btns(4'b0000);
      tick();
      @(negedge clk);
      check($sformatf("vec%0d_present", i), atc_bits, vecs[i].exp_atc);
      check($sformatf("vec%0d_busy", i), busy, 1'b1);
      check($sformatf("vec%0d_level", i), fifo_level, 0);
      tick();
      atc_ack = 1'b1;
      tick();
      atc_ack = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_ack", i), atc_bits, {3'b000, vecs[i].ovf, 4'h0});
      tick();
      @(negedge clk);
      check($sformatf("vec%0d_holdoff_busy", i), busy, 1'b1);
      tick();
      @(negedge clk);
      check($sformatf("vec%0d_idle_busy", i), busy, 1'b0);
      arith_ovf = 1'b0;
      repeat (2) tick();
    end

    // Ack handshake and holdoff gap: ADD presented, POP queued behind it
    tick();
    set_btns(B_ADD);
    repeat (4) tick();
    set_btns(4'b0000);
    tick();
    @(negedge clk);
    check("hs_add", atc_bits, 8'h02);
    tick();
    press(B_POP);
    @(negedge clk);
    check("hs_pop_queued", fifo_level, 1);
    check("hs_add_held", atc_bits, 8'h02);
    tick();
    atc_ack = 1'b1;
    tick();
    atc_ack = 1'b0;
    @(negedge clk);
    check("hs_a1", atc_bits, 8'h00);
    tick();
    @(negedge clk);
    check("hs_a2", atc_bits, 8'h00);
    tick();
    @(negedge clk);
    check("hs_a3", atc_bits, 8'h00);
    tick();
    @(negedge clk);
    check("hs_a4", atc_bits, 8'h04);
    tick();
    atc_ack = 1'b1;
    tick();
    atc_ack = 1'b0;
    repeat (4) tick();

    // Priority: all four buttons rise together
    set_btns(4'b1111);
    repeat (3) tick();
    set_btns(4'b0000);
    repeat (2) tick();
    @(negedge clk);
    check("prio_first", atc_bits, 8'h01);
    repeat (3) tick();
    @(negedge clk);
    check("prio_level", fifo_level, 3);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h08);
    for (int k = 0; k < 4; k++) expect_next($sformatf("prio%0d", k));
    check("prio_drop", drop_cnt, 8'h00);
    repeat (3) tick();
    @(negedge clk);
    check("prio_idle", busy, 1'b0);

    // Overflow and drops with no acks
    tick();
    press(B_MULT);
    press(B_ADD);
    press(B_POP);
    press(B_PUSH);
    press(B_MULT);
    repeat (2) tick();
    @(negedge clk);
    check("ovf_level_full", fifo_level, 4);
    check("ovf_present", atc_bits, 8'h01);
    tick();
    press(B_ADD);
    @(negedge clk);
    check("ovf_wait_nodrop", drop_cnt, 8'h00);
    check("ovf_level_hold", fifo_level, 4);
    tick();
    press(B_ADD);
    @(negedge clk);
    check("ovf_drop1", drop_cnt, 8'h01);
    tick();
    press(B_POP);
    @(negedge clk);
    check("ovf_pop_pending", drop_cnt, 8'h01);
    tick();
    repeat (300) press(B_ADD);
    @(negedge clk);
    check("ovf_drop_sat", drop_cnt, 8'hFF);

    // Drain: pending ADD/POP enter the full FIFO on the cycle of each pop
    exp_q.push_back(8'h01);
    expect_next("drain0");
    repeat (3) tick();
    @(negedge clk);
    check("drain_wr_with_pop_level", fifo_level, 4);
    check("drain_second", atc_bits, 8'h02);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h08);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h04);
    for (int k = 1; k <= 6; k++) expect_next($sformatf("drain%0d", k));
    repeat (3) tick();
    @(negedge clk);
    check("drain_idle", busy, 1'b0);
    check("drain_level", fifo_level, 0);
    check("drain_drop_hold", drop_cnt, 8'hFF);

    // Overflow flag while MULT is presented
    tick();
    set_btns(B_MULT);
    repeat (4) tick();
    set_btns(4'b0000);
    tick();
    @(negedge clk);
    check("aovf_mult", atc_bits, 8'h01);
    tick();
    arith_ovf = 1'b1;
    @(negedge clk);
    check("aovf_delay", atc_bits, 8'h01);
    tick();
    @(negedge clk);
    check("aovf_set", atc_bits, 8'h11);
    tick();
    atc_ack = 1'b1;
    tick();
    atc_ack = 1'b0;
    @(negedge clk);
    check("aovf_ack", atc_bits, 8'h10);
    tick();
    arith_ovf = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("aovf_clear", atc_bits, 8'h00);
    repeat (3) tick();

    // Reset mid-operation with three entries queued
    press(B_MULT);
    press(B_ADD);
    press(B_POP);
    press(B_PUSH);
    @(negedge clk);
    check("mrst_level_before", fifo_level, 3);
    check("mrst_atc_before", atc_bits, 8'h01);
    #2;
    reset_n = 1'b0;
    #1;
    check("mrst_atc", atc_bits, 8'h00);
    check("mrst_level", fifo_level, 0);
    check("mrst_busy", busy, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("mrst_busy_after", busy, 1'b0);
    check("mrst_atc_after", atc_bits, 8'h00);
    check("mrst_drop_after", drop_cnt, 8'h00);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
